// File: rtl/sram_read_demapper_if.sv
// sram_read_demapper_if
// ---------------------
// Bundles the request port, response port, SRAM read port and key-load
// signals of the SRAM read demapper so that they can be passed as one port.
//
// Signals:
//   key_load, key_in          load a new TRNG key (requester side)
//   req_valid, req_ready,     read request handshake and address
//   req_addr
//   sram_re, sram_addr,       SRAM macro read port (enable pulse, address,
//   sram_rdata                masked data returning from the macro)
//   rsp_valid, rsp_ready,     unmasked response handshake and data
//   rsp_data
//   busy                      block is not idle
//
// Modports:
//   slave  - the demapper itself
//   master - the environment around it (requester, consumer, SRAM macro)
interface sram_read_demapper_if #(
    parameter int DATA_WIDTH = 52,
    parameter int TRNG_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();

    logic                  key_load;
    logic [TRNG_WIDTH-1:0] key_in;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  sram_re;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  busy;

    modport slave (
        input  key_load,
        input  key_in,
        input  req_valid,
        output req_ready,
        input  req_addr,
        output sram_re,
        output sram_addr,
        input  sram_rdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output busy
    );

    modport master (
        output key_load,
        output key_in,
        output req_valid,
        input  req_ready,
        output req_addr,
        input  sram_re,
        input  sram_addr,
        output sram_rdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  busy
    );

endinterface

// File: rtl/sram_read_demapper.sv
// sram_read_demapper
// ------------------
// Read-side counterpart of the TRNG write mapper. Accepts one read request,
// issues a single SRAM read, XORs the returned word with the key-derived mask
// and presents the plaintext on a valid/ready response port. One request is
// in flight at a time; the minimum issue interval is READ_LATENCY+3 cycles.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sram_read_demapper_if.slave: key load, request handshake,
//          SRAM read port, response handshake, busy flag
//
// Parameters:
//   DATA_WIDTH    width of the stored/returned word
//   TRNG_WIDTH    width of the TRNG key
//   ADDR_WIDTH    SRAM address width
//   READ_LATENCY  cycles from the sram_re-high cycle to valid sram_rdata
//                 (legal range 1..15, fits the 4-bit latency counter)
module sram_read_demapper #(
    parameter int DATA_WIDTH   = 52,
    parameter int TRNG_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_read_demapper_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [TRNG_WIDTH-1:0] key_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [3:0]            cnt_q;
    logic                  req_ready_q;
    logic                  sram_re_q;
    logic [ADDR_WIDTH-1:0] sram_addr_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  busy_q;
    logic                  accept;
    logic                  capture;

    // Repeat the key across the data word; the last partial chunk takes the
    // key LSBs. Must stay bit-identical to the write mapper's expansion.
    function automatic logic [DATA_WIDTH-1:0] expand_key(input logic [TRNG_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            m[i] = k[i % TRNG_WIDTH];
        end
        return m;
    endfunction

    // Gating acceptance on the registered req_ready keeps the block deaf
    // during the first cycle after reset release.
    assign accept  = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;

    // The counter is loaded with READ_LATENCY at acceptance, so it reaches
    // zero exactly in the cycle where sram_rdata is valid.
    assign capture = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Next-state decode for the single-outstanding-request FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)        state_d = ST_WAIT;
            ST_WAIT: if (capture)       state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // All outputs are flops decoded from the next state so nothing
    // combinational reaches the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            sram_re_q   <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            sram_re_q   <= accept;
            if (accept) begin
                sram_addr_q <= bus.req_addr;
            end
        end
    end

    // Key register and per-request mask snapshot. The snapshot reads the key
    // register before any same-cycle key_load lands, so a racing load only
    // affects the following request, and loads during WAIT/RESP never touch
    // the word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            mask_q <= '0;
        end else begin
            if (bus.key_load) begin
                key_q <= bus.key_in;
            end
            if (accept) begin
                mask_q <= expand_key(key_q);
            end
        end
    end

    // Latency counter and response capture. rsp_data only changes on the
    // capture edge, so it holds steady through any backpressure in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= 4'(READ_LATENCY);
            end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rsp_data_q <= bus.sram_rdata ^ mask_q;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.sram_re   = sram_re_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sram_read_demapper.sv
// tb_sram_read_demapper
// ---------------------
// Directed bench for sram_read_demapper. Two instances are used: d1 with
// READ_LATENCY=1 for the key/unmask/backpressure cases and d4 with
// READ_LATENCY=4 for latency timing and reset during WAIT. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_sram_read_demapper;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    sram_read_demapper_if #(.DATA_WIDTH(52), .TRNG_WIDTH(32), .ADDR_WIDTH(10)) b1 ();
    sram_read_demapper_if #(.DATA_WIDTH(52), .TRNG_WIDTH(32), .ADDR_WIDTH(10)) b4 ();

    sram_read_demapper #(
        .DATA_WIDTH(52), .TRNG_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)
    ) d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    sram_read_demapper #(
        .DATA_WIDTH(52), .TRNG_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(4)
    ) d4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One full READ_LATENCY=1 transaction on d1; optional key_load in the
    // acceptance cycle. Wrong-cycle rdata is driven with filler patterns.
    task automatic read1(input string tag, input logic [9:0] addr, input logic [51:0] rdata,
                         input logic [51:0] exp, input logic ld, input logic [31:0] kv);
        b1.req_valid = 1'b1;
        b1.req_addr  = addr;
        b1.key_load  = ld;
        b1.key_in    = kv;
        tick();
        b1.req_valid  = 1'b0;
        b1.key_load   = 1'b0;
        b1.sram_rdata = 52'hAAAAAAAAAAAAA;
        check_output({tag, ".re_c1"},    64'(b1.sram_re),   64'd1);
        check_output({tag, ".addr_c1"},  64'(b1.sram_addr), 64'(addr));
        check_output({tag, ".valid_c1"}, 64'(b1.rsp_valid), 64'd0);
        tick();
        b1.sram_rdata = rdata;
        check_output({tag, ".re_c2"},    64'(b1.sram_re),   64'd0);
        check_output({tag, ".valid_c2"}, 64'(b1.rsp_valid), 64'd0);
        tick();
        b1.sram_rdata = 52'h5555555555555;
        check_output({tag, ".valid_c3"}, 64'(b1.rsp_valid), 64'd1);
        check_output({tag, ".data"},     64'(b1.rsp_data),  64'(exp));
        b1.rsp_ready = 1'b1;
        tick();
        b1.rsp_ready = 1'b0;
        check_output({tag, ".valid_done"}, 64'(b1.rsp_valid), 64'd0);
        check_output({tag, ".ready_done"}, 64'(b1.req_ready), 64'd1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        b1.key_load = 1'b0; b1.key_in = '0; b1.req_valid = 1'b0; b1.req_addr = '0;
        b1.sram_rdata = '0; b1.rsp_ready = 1'b0;
        b4.key_load = 1'b0; b4.key_in = '0; b4.req_valid = 1'b0; b4.req_addr = '0;
        b4.sram_rdata = '0; b4.rsp_ready = 1'b0;

        // Reset values
        tick();
        tick();
        check_output("rst.req_ready", 64'(b1.req_ready), 64'd0);
        check_output("rst.sram_re",   64'(b1.sram_re),   64'd0);
        check_output("rst.sram_addr", 64'(b1.sram_addr), 64'd0);
        check_output("rst.rsp_valid", 64'(b1.rsp_valid), 64'd0);
        check_output("rst.rsp_data",  64'(b1.rsp_data),  64'd0);
        check_output("rst.busy",      64'(b1.busy),      64'd0);
        rst_n = 1'b1;
        tick();
        check_output("rel.req_ready1", 64'(b1.req_ready), 64'd1);
        check_output("rel.req_ready4", 64'(b4.req_ready), 64'd1);

        // Key 0 is a passthrough
        read1("pass", 10'h005, 52'h123456789ABCD, 52'h123456789ABCD, 1'b0, 32'h0);

        // Unmask with key 0xDEADBEEF -> mask 0xDBEEFDEADBEEF
        b1.key_load = 1'b1;
        b1.key_in   = 32'hDEADBEEF;
        tick();
        b1.key_load = 1'b0;
        read1("unmask0", 10'h010, 52'hDBEEFDEADBEEF, 52'h0, 1'b0, 32'h0);
        read1("unmask1", 10'h011, 52'h0, 52'hDBEEFDEADBEEF, 1'b0, 32'h0);

        // key_load racing acceptance: old key for this word, new key after
        read1("race_old", 10'h020, 52'h0, 52'hDBEEFDEADBEEF, 1'b1, 32'h0);
        read1("race_new", 10'h021, 52'h0, 52'h0, 1'b0, 32'h0);

        // Backpressure, plus a key_load during WAIT that must not touch the
        // in-flight word. Key 0x12345678 -> mask 0x4567812345678.
        b1.key_load = 1'b1;
        b1.key_in   = 32'h12345678;
        tick();
        b1.key_load  = 1'b0;
        b1.req_valid = 1'b1;
        b1.req_addr  = 10'h3FF;
        tick();
        b1.req_addr   = 10'h155;
        b1.key_load   = 1'b1;
        b1.key_in     = 32'hFFFFFFFF;
        b1.sram_rdata = 52'hAAAAAAAAAAAAA;
        check_output("bp.addr", 64'(b1.sram_addr), 64'h3FF);
        tick();
        b1.key_load   = 1'b0;
        b1.sram_rdata = 52'h0;
        tick();
        b1.sram_rdata = 52'h5555555555555;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp.valid%0d", i), 64'(b1.rsp_valid), 64'd1);
            check_output($sformatf("bp.data%0d", i),  64'(b1.rsp_data),  64'h4567812345678);
            check_output($sformatf("bp.ready%0d", i), 64'(b1.req_ready), 64'd0);
            check_output($sformatf("bp.busy%0d", i),  64'(b1.busy),      64'd1);
            check_output($sformatf("bp.re%0d", i),    64'(b1.sram_re),   64'd0);
            tick();
        end
        b1.rsp_ready = 1'b1;
        tick();
        b1.rsp_ready = 1'b0;
        check_output("bp.idle_ready", 64'(b1.req_ready), 64'd1);
        check_output("bp.idle_re",    64'(b1.sram_re),   64'd0);
        tick();
        b1.req_valid  = 1'b0;
        b1.sram_rdata = 52'hAAAAAAAAAAAAA;
        check_output("bp2.re",   64'(b1.sram_re),   64'd1);
        check_output("bp2.addr", 64'(b1.sram_addr), 64'h155);
        tick();
        b1.sram_rdata = 52'h0F0F0F0F0F0F0;
        tick();
        check_output("bp2.valid", 64'(b1.rsp_valid), 64'd1);
        check_output("bp2.data",  64'(b1.rsp_data),  64'hF0F0F0F0F0F0F);
        b1.rsp_ready = 1'b1;
        tick();
        b1.rsp_ready = 1'b0;

        // READ_LATENCY=4: one sram_re pulse, capture in cycle 5, valid in 6
        b4.key_load = 1'b1;
        b4.key_in   = 32'hDEADBEEF;
        tick();
        b4.key_load  = 1'b0;
        b4.req_valid = 1'b1;
        b4.req_addr  = 10'h2A5;
        tick();
        b4.req_valid  = 1'b0;
        b4.sram_rdata = 52'hFFFFFFFFFFFFF;
        check_output("l4.re_c1",   64'(b4.sram_re),   64'd1);
        check_output("l4.addr_c1", 64'(b4.sram_addr), 64'h2A5);
        for (int c = 2; c <= 5; c++) begin
            tick();
            b4.sram_rdata = (c == 5) ? 52'h0 : 52'h1111111111111 * 52'(c);
            check_output($sformatf("l4.re_c%0d", c),    64'(b4.sram_re),   64'd0);
            check_output($sformatf("l4.valid_c%0d", c), 64'(b4.rsp_valid), 64'd0);
        end
        tick();
        b4.sram_rdata = 52'h7777777777777;
        check_output("l4.valid_c6", 64'(b4.rsp_valid), 64'd1);
        check_output("l4.data",     64'(b4.rsp_data),  64'hDBEEFDEADBEEF);
        b4.rsp_ready = 1'b1;
        tick();
        b4.rsp_ready = 1'b0;
        check_output("l4.done_ready", 64'(b4.req_ready), 64'd1);

        // Reset during WAIT drops the request entirely
        b4.req_valid = 1'b1;
        b4.req_addr  = 10'h0AA;
        tick();
        b4.req_valid = 1'b0;
        tick();
        check_output("rw.busy_before", 64'(b4.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_output("rw.busy",      64'(b4.busy),      64'd0);
        check_output("rw.req_ready", 64'(b4.req_ready), 64'd0);
        check_output("rw.sram_addr", 64'(b4.sram_addr), 64'd0);
        check_output("rw.rsp_valid", 64'(b4.rsp_valid), 64'd0);
        check_output("rw.rsp_data",  64'(b4.rsp_data),  64'd0);
        check_output("rw.d1_data",   64'(b1.rsp_data),  64'd0);
        tick();
        rst_n = 1'b1;
        b4.sram_rdata = 52'h123456789ABCD;
        tick();
        check_output("rw.ready_after", 64'(b4.req_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("rw.novalid%0d", i), 64'(b4.rsp_valid), 64'd0);
            check_output($sformatf("rw.idle%0d", i),    64'(b4.busy),      64'd0);
            tick();
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_read_demapper.md
Name: sram_read_demapper

Overview:
Read-side counterpart of the write-path TRNG data mapper. It accepts a read request, issues one SRAM read and unmasks the returned word by XOR with the stored TRNG key. It presents the plaintext word on a valid/ready response port. It sits between the SRAM macro read port and the consumer.

Parameters:
DATA_WIDTH, 52, width of stored/returned data word
TRNG_WIDTH, 32, width of key (TRNG value used at write time)
ADDR_WIDTH, 10, SRAM address width
READ_LATENCY, 1, cycles from sram_re-high cycle to sram_rdata valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_load  in  1  load key_in into key register this cycle
key_in  in  TRNG_WIDTH  TRNG value used by the write-side mapper
req_valid  in  1  read request valid
req_ready  out  1  block can accept a request
req_addr  in  ADDR_WIDTH  read address
sram_re  out  1  SRAM read enable, one-cycle pulse per request
sram_addr  out  ADDR_WIDTH  SRAM read address
sram_rdata  in  DATA_WIDTH  masked data from SRAM
rsp_valid  out  1  unmasked data valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_WIDTH  unmasked data
busy  out  1  high whenever state != IDLE

Behaviour:
- Mask expansion:
  - mask[k*TRNG_WIDTH+j] = key[j] for every bit index < DATA_WIDTH.
  - The final partial chunk uses the key LSBs (key[DATA_WIDTH mod TRNG_WIDTH - 1:0]).
  - This must match the write mapper exactly, so unmask(mask(x)) = x.
- Key register:
  - Reset value 0; with key 0 the block is a passthrough.
  - Updated on any cycle with key_load=1, in any state.
  - The key is snapshotted into a request-local mask register on request acceptance.
  - A key_load in the same cycle as acceptance: the request uses the OLD key; the new key applies from the next request.
  - A key_load during WAIT or RESP does not affect the in-flight word.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch req_addr into sram_addr, snapshot key, set sram_re=1 for exactly the next cycle, load latency counter with READ_LATENCY, and go to WAIT.
  - WAIT: sram_re=0 after its single cycle. The counter decrements each cycle. In the cycle where sram_rdata is valid (READ_LATENCY cycles after the sram_re-high cycle), capture rsp_data <= sram_rdata ^ mask at that cycle's closing edge and go to RESP.
  - RESP: rsp_valid=1 and rsp_data held stable until rsp_ready=1. On rsp_valid&rsp_ready, go to IDLE.
- Latency:
  - Acceptance edge at the end of cycle 0 -> sram_re high in cycle 1 -> rsp_valid high in cycle READ_LATENCY+2.
  - Minimum issue interval is READ_LATENCY+3 cycles (no back-to-back overlap). req_ready is 0 in WAIT and RESP.
- All outputs are registered.
- Reset values: req_ready=0 while rst_n=0, and 1 from the first cycle after deassertion. sram_re=0, sram_addr=0, rsp_valid=0, rsp_data=0, busy=0, key=0, state=IDLE.
- Reset mid-operation: asynchronous clear of everything. The pending request and captured data are dropped, no response is produced, and sram_rdata is ignored afterwards.
- req_valid in WAIT/RESP is not accepted, and the requester must hold it.
- rsp_ready high while rsp_valid=0 has no effect.
- sram_rdata is don't-care outside the capture cycle.

Test Plan:
- Key passthrough: after reset, no key_load, request addr 0x005, sram_rdata=0x123456789ABCD at capture -> rsp_data=0x123456789ABCD, and rsp_valid rises 3 cycles after acceptance (READ_LATENCY=1).
- Unmask: key_load key_in=0xDEADBEEF (mask 0xDBEEFDEADBEEF), sram_rdata=0xDBEEFDEADBEEF -> rsp_data=0x0000000000000; sram_rdata=0 -> rsp_data=0xDBEEFDEADBEEF.
- Key race: key=0xDEADBEEF, key_load 0x00000000 in the same cycle as acceptance, rdata=0 -> rsp_data=0xDBEEFDEADBEEF; the next request with rdata=0 -> rsp_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 and busy=1 throughout, and a second req_valid is not accepted until the handshake completes.
- Latency parameter: READ_LATENCY=4 -> exactly one sram_re pulse with sram_addr=req_addr, capture exactly 4 cycles later, rsp_valid in cycle 6; wrong-cycle rdata values are ignored.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> all outputs go to 0 immediately, no rsp_valid after release, and req_ready=1 in the first cycle after release.
